// File: rtl/pg_prefix_resolver.sv
// pg_prefix_resolver
//   Multi-cycle carry back end for a row of pg cells. It captures per-bit
//   generate/propagate vectors and a carry-in, then resolves every carry with
//   an iterative Kogge-Stone prefix at one level per clock. It returns the sum
//   and the carry-out through a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   g_in/p_in/c_in are valid
//   in_ready   block can accept a vector (idle)
//   g_in       per-bit generate (x & y)
//   p_in       per-bit propagate (x ^ y)
//   c_in       carry into bit 0
//   out_valid  sum/c_out are valid
//   out_ready  downstream accepts the result
//   sum        p_in ^ {carries, c_in}
//   c_out      carry out of bit WIDTH-1
//   busy       a vector is being combined or is waiting to be taken
module pg_prefix_resolver #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             busy
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned LVL_W  = $clog2(LEVELS + 1);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StCombine = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] praw_q, praw_d;
    logic             cin_q, cin_d;

    logic [WIDTH-1:0] g_lvl, p_lvl;
    logic             last_lvl;

    // One prefix level with span d = 1 << lvl. Shifting in zeros leaves G
    // untouched for i < d; P needs those low bits forced high to stay unchanged.
    always_comb begin
        int unsigned shamt;
        logic [WIDTH-1:0] low_mask;
        shamt    = 32'd1 << lvl_q;
        low_mask = ~({WIDTH{1'b1}} << shamt);
        g_lvl    = g_q | (p_q & (g_q << shamt));
        p_lvl    = p_q & ((p_q << shamt) | low_mask);
    end

    assign last_lvl = (lvl_q == LVL_W'(LEVELS - 1));

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        g_d     = g_q;
        p_d     = p_q;
        praw_d  = praw_q;
        cin_d   = cin_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    // Fold the carry-in into bit 0 so the prefix sees it as a generate.
                    g_d     = {g_in[WIDTH-1:1], g_in[0] | (p_in[0] & c_in)};
                    p_d     = p_in;
                    praw_d  = p_in;
                    cin_d   = c_in;
                    lvl_d   = '0;
                    state_d = StCombine;
                end
            end
            StCombine: begin
                g_d   = g_lvl;
                p_d   = p_lvl;
                lvl_d = lvl_q + LVL_W'(1);
                if (last_lvl) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lvl_q   <= '0;
            g_q     <= '0;
            p_q     <= '0;
            praw_q  <= '0;
            cin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            g_q     <= g_d;
            p_q     <= p_d;
            praw_q  <= praw_d;
            cin_q   <= cin_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);

    // After all levels g_q[i] is the carry out of bit i.
    assign sum   = praw_q ^ {g_q[WIDTH-2:0], cin_q};
    assign c_out = g_q[WIDTH-1];

endmodule

// File: tb/tb_pg_prefix_resolver.sv
module tb_pg_prefix_resolver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Index 0: WIDTH=8, 1: WIDTH=5, 2: WIDTH=32
    logic [63:0] g_v [3];
    logic [63:0] p_v [3];
    logic        c_v [3];
    logic        iv  [3];
    logic        ordy[3];
    logic [63:0] sum_v [3];
    logic        co [3];
    logic        ov [3];
    logic        ir [3];
    logic        bz [3];

    logic [7:0]  sum8;
    logic [4:0]  sum5;
    logic [31:0] sum32;

    int tests = 0;
    int fails = 0;

    pg_prefix_resolver #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .g_in(g_v[0][7:0]), .p_in(p_v[0][7:0]), .c_in(c_v[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum8), .c_out(co[0]), .busy(bz[0])
    );
    pg_prefix_resolver #(.WIDTH(5)) u_w5 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .g_in(g_v[1][4:0]), .p_in(p_v[1][4:0]), .c_in(c_v[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum5), .c_out(co[1]), .busy(bz[1])
    );
    pg_prefix_resolver #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .g_in(g_v[2][31:0]), .p_in(p_v[2][31:0]), .c_in(c_v[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum32), .c_out(co[2]), .busy(bz[2])
    );

    assign sum_v[0] = 64'(sum8);
    assign sum_v[1] = 64'(sum5);
    assign sum_v[2] = 64'(sum32);

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a vector and return at the first falling edge after it was taken.
    task automatic start(input int s, input logic [63:0] g, input logic [63:0] p,
                         input logic c);
        int n;
        n = 0;
        g_v[s] = g;
        p_v[s] = p;
        c_v[s] = c;
        while (!ir[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 65'(ir[s]), 65'(1));
        iv[s] = 1'b1;
        @(negedge clk);
        iv[s] = 1'b0;
    endtask

    // Count falling edges after the accept edge until out_valid.
    task automatic wait_done(input int s, output int lat);
        lat = 0;
        while (!ov[s] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) check("done_timeout", 65'(ov[s]), 65'(1));
    endtask

    task automatic release_result(input int s);
        ordy[s] = 1'b1;
        @(negedge clk);
        ordy[s] = 1'b0;
    endtask

    task automatic directed(input string tag, input int s, input logic [63:0] g,
                            input logic [63:0] p, input logic c, input int lv,
                            input logic [63:0] es, input logic ec);
        int lat;
        start(s, g, p, c);
        check({tag, "_busy"}, 65'(bz[s]), 65'(1));
        check({tag, "_inready"}, 65'(ir[s]), 65'(0));
        wait_done(s, lat);
        check({tag, "_latency"}, 65'(lat), 65'(lv));
        check({tag, "_sum"}, 65'(sum_v[s]), 65'(es));
        check({tag, "_cout"}, 65'(co[s]), 65'(ec));
        release_result(s);
        check({tag, "_idle_valid"}, 65'(ov[s]), 65'(0));
        check({tag, "_idle_ready"}, 65'(ir[s]), 65'(1));
    endtask

    task automatic rand_run(input int s, input int w, input int lv, input int n);
        logic [63:0] m, x, y;
        logic        c;
        logic [64:0] obs, exp;
        int          lat;
        m = (64'd1 << w) - 64'd1;
        for (int k = 0; k < n; k++) begin
            x = {$urandom, $urandom} & m;
            y = {$urandom, $urandom} & m;
            c = 1'($urandom_range(0, 1));
            ordy[s] = 1'($urandom_range(0, 1));
            start(s, x & y, x ^ y, c);
            wait_done(s, lat);
            check("rand_latency", 65'(lat), 65'(lv));
            obs = (65'(co[s]) << w) | 65'(sum_v[s]);
            exp = 65'(x) + 65'(y) + 65'(c);
            check("rand_result", obs, exp);
            repeat ($urandom_range(0, 2)) begin
                ordy[s] = 1'b0;
                @(negedge clk);
            end
            release_result(s);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            g_v[i] = '0; p_v[i] = '0; c_v[i] = 1'b0; iv[i] = 1'b0; ordy[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_inready", 65'(ir[0]), 65'(1));
        check("rst_outvalid", 65'(ov[0]), 65'(0));
        check("rst_sum", 65'(sum_v[0]), 65'(0));
        check("rst_cout", 65'(co[0]), 65'(0));
        check("rst_busy", 65'(bz[0]), 65'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // 0x0F + 0x01
        directed("t1", 0, 64'h01, 64'h0E, 1'b0, 3, 64'h10, 1'b0);
        // 0xFF + 0x01: ripple across every bit
        directed("t2", 0, 64'h01, 64'hFE, 1'b0, 3, 64'h00, 1'b1);
        directed("t3a", 0, 64'h00, 64'hFF, 1'b1, 3, 64'h00, 1'b1);
        directed("t3b", 0, 64'h00, 64'h00, 1'b1, 3, 64'h01, 1'b0);
        // Illegal pg pair processed by the equations
        directed("illegal", 0, 64'hFF, 64'hFF, 1'b0, 3, 64'h01, 1'b1);
        // Non-power-of-two width: 0x1F + 0x01
        directed("w5", 1, 64'h01, 64'h1E, 1'b0, 3, 64'h00, 1'b1);

        // Backpressure: 0x35 + 0x0A + 1 = 0x40, held while in_valid pulses
        begin
            int lat;
            start(0, 64'h00, 64'h3F, 1'b1);
            wait_done(0, lat);
            check("bp_latency", 65'(lat), 65'(3));
            for (int k = 0; k < 5; k++) begin
                g_v[0] = 64'hFF;
                p_v[0] = 64'h00;
                c_v[0] = 1'b1;
                iv[0]  = k[0];
                @(negedge clk);
                check("bp_sum", 65'(sum_v[0]), 65'(64'h40));
                check("bp_cout", 65'(co[0]), 65'(0));
                check("bp_valid", 65'(ov[0]), 65'(1));
                check("bp_inready", 65'(ir[0]), 65'(0));
            end
            iv[0] = 1'b0;
            release_result(0);
            check("bp_rel_ready", 65'(ir[0]), 65'(1));
            check("bp_rel_valid", 65'(ov[0]), 65'(0));
            @(negedge clk);
            check("bp_no_capture", 65'(bz[0]), 65'(0));
        end

        // Reset one cycle after accept
        start(0, 64'h01, 64'h0E, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 65'(ov[0]), 65'(0));
        check("mid_rst_sum", 65'(sum_v[0]), 65'(0));
        check("mid_rst_ready", 65'(ir[0]), 65'(1));
        check("mid_rst_busy", 65'(bz[0]), 65'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        directed("post_rst", 0, 64'h01, 64'h0E, 1'b0, 3, 64'h10, 1'b0);

        rand_run(0, 8, 3, 1000);
        rand_run(1, 5, 3, 1000);
        rand_run(2, 32, 5, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
